// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice: icodes, register
// sentinel, status codes, control FSM states and the stall/bubble bundle.
package y86_pkg;

  localparam int unsigned Y86_ICODE_W = 4;
  localparam int unsigned Y86_STAT_W  = 3;

  localparam logic [Y86_ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [Y86_ICODE_W-1:0] I_NOP    = 4'h1;
  localparam logic [Y86_ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [Y86_ICODE_W-1:0] I_IRMOVQ = 4'h3;
  localparam logic [Y86_ICODE_W-1:0] I_RMMOVQ = 4'h4;
  localparam logic [Y86_ICODE_W-1:0] I_MRMOVQ = 4'h5;
  localparam logic [Y86_ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [Y86_ICODE_W-1:0] I_JXX    = 4'h7;
  localparam logic [Y86_ICODE_W-1:0] I_CALL   = 4'h8;
  localparam logic [Y86_ICODE_W-1:0] I_RET    = 4'h9;
  localparam logic [Y86_ICODE_W-1:0] I_PUSHQ  = 4'hA;
  localparam logic [Y86_ICODE_W-1:0] I_POPQ   = 4'hB;

  localparam logic [Y86_STAT_W-1:0] S_AOK = 3'd1;
  localparam logic [Y86_STAT_W-1:0] S_HLT = 3'd2;
  localparam logic [Y86_STAT_W-1:0] S_ADR = 3'd3;
  localparam logic [Y86_STAT_W-1:0] S_INS = 3'd4;

  // Control FSM: normal flow, draining after a memory-stage exception, frozen.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  // Stall/bubble pins for the stage registers plus the CC write permit.
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic set_cc_en;
  } ctrl_sig_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard detection: load-use, jump mispredict, exceptions
// leaving memory and sitting in writeback. RNONE (all ones) never matches.
module pipe_hazard_detect
  import y86_pkg::*;
#(
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ICODE_W = 4,
  parameter int unsigned STAT_W  = 3
) (
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic               e_cnd,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  output logic               load_use_c,
  output logic               mispred_c,
  output logic               exc_m_c,
  output logic               exc_w_c
);

  localparam logic [REG_W-1:0] RNONE = '1;

  logic is_load;

  // Hazard terms derived straight from the execute/memory/writeback fields.
  always_comb begin
    is_load    = (E_icode == ICODE_W'(I_MRMOVQ)) || (E_icode == ICODE_W'(I_POPQ));
    load_use_c = is_load && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispred_c  = (E_icode == ICODE_W'(I_JXX)) && !e_cnd;
    exc_m_c    = (m_stat != STAT_W'(S_AOK));
    exc_w_c    = (W_stat != STAT_W'(S_AOK));
  end

endmodule

// File: rtl/y86_pipe_ctrl_unit.sv
// Pipeline control unit for the 5-stage Y86-64 pipe: stall/bubble decisions,
// counted ret stall window and a RUN/DRAIN/HALT status FSM.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall, bubble and
// mispredict counters.
module y86_pipe_ctrl_unit
  import y86_pkg::*;
#(
  parameter int unsigned REG_W     = 4,
  parameter int unsigned ICODE_W   = 4,
  parameter int unsigned STAT_W    = 3,
  parameter int unsigned RET_DEPTH = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_cnd,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_stall,
  output logic               set_cc_en,
  output logic [STAT_W-1:0]  stat,
  output logic               halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
`endif
);

  localparam int unsigned RC_W = $clog2(RET_DEPTH + 1);

  // Reject configurations the ret window or counters cannot represent.
  if (RET_DEPTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("y86_pipe_ctrl_unit: RET_DEPTH and CNT_W must be >= 1");
  end

  ctrl_state_e       state, next_state;
  logic [RC_W-1:0]   ret_cnt, ret_cnt_d, ret_cnt_dec;
  logic [STAT_W-1:0] stat_d;
  logic              halted_d;
  ctrl_sig_t         ctl;

  logic load_use, mispred, exc_m, exc_w;
  logic ret_hit, ret_act;

  pipe_hazard_detect #(
    .REG_W   (REG_W),
    .ICODE_W (ICODE_W),
    .STAT_W  (STAT_W)
  ) u_hazard (
    .E_icode    (E_icode),
    .E_dstM     (E_dstM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .e_cnd      (e_cnd),
    .m_stat     (m_stat),
    .W_stat     (W_stat),
    .load_use_c (load_use),
    .mispred_c  (mispred),
    .exc_m_c    (exc_m),
    .exc_w_c    (exc_w)
  );

  // A ret in decode only opens the window once it is not held by a higher hazard.
  always_comb begin
    ret_hit     = (D_icode == ICODE_W'(I_RET)) && !load_use && !mispred;
    ret_act     = (ret_cnt != '0) || ret_hit;
    ret_cnt_dec = (ret_cnt != '0) ? ret_cnt - RC_W'(1) : '0;
  end

  // State, ret counter and architectural status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      ret_cnt <= '0;
      stat    <= STAT_W'(S_AOK);
      halted  <= 1'b0;
    end else begin
      state   <= next_state;
      ret_cnt <= ret_cnt_d;
      stat    <= stat_d;
      halted  <= halted_d;
    end
  end

  // Next-state and stall/bubble decode; reset forces a flush pattern.
  always_comb begin
    next_state = state;
    ret_cnt_d  = ret_cnt;
    stat_d     = stat;
    halted_d   = halted;
    ctl        = '0;

    unique case (state)
      ST_RUN: begin
        ctl.f_stall   = load_use || ret_act;
        ctl.d_stall   = load_use;
        ctl.d_bubble  = !load_use && (mispred || ret_act);
        ctl.e_bubble  = load_use || mispred;
        ctl.m_bubble  = exc_m || exc_w;
        ctl.w_stall   = exc_w;
        ctl.set_cc_en = (E_icode == ICODE_W'(I_OPQ)) && !exc_m && !exc_w;
        ret_cnt_d     = (ret_hit && (ret_cnt == '0)) ? RC_W'(RET_DEPTH) : ret_cnt_dec;
        if (exc_w) begin
          next_state = ST_HALT;
          stat_d     = W_stat;
          halted_d   = 1'b1;
        end else if (exc_m) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ctl.f_stall  = 1'b1;
        ctl.d_bubble = 1'b1;
        ctl.e_bubble = 1'b1;
        ctl.m_bubble = 1'b1;
        ctl.w_stall  = exc_w;
        ret_cnt_d    = ret_cnt_dec;
        if (exc_w) begin
          next_state = ST_HALT;
          stat_d     = W_stat;
          halted_d   = 1'b1;
        end
      end
      ST_HALT: begin
        ctl.f_stall  = 1'b1;
        ctl.d_stall  = 1'b1;
        ctl.w_stall  = 1'b1;
        ctl.e_bubble = 1'b1;
        ctl.m_bubble = 1'b1;
      end
      default: begin
        next_state = ST_RUN;
      end
    endcase

    if (rst) begin
      ctl          = '0;
      ctl.d_bubble = 1'b1;
      ctl.e_bubble = 1'b1;
      ctl.m_bubble = 1'b1;
    end
  end

  assign F_stall   = ctl.f_stall;
  assign D_stall   = ctl.d_stall;
  assign D_bubble  = ctl.d_bubble;
  assign E_bubble  = ctl.e_bubble;
  assign M_bubble  = ctl.m_bubble;
  assign W_stall   = ctl.w_stall;
  assign set_cc_en = ctl.set_cc_en;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating event counters, active only while the pipe is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (ctl.f_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((ctl.d_bubble || ctl.e_bubble) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (mispred && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_y86_pipe_ctrl_unit.sv
// Scoreboard bench for y86_pipe_ctrl_unit: each step drives one cycle of
// pipeline state, pushes the expected controls, and pops them mid-cycle.
module tb_y86_pipe_ctrl_unit;

  localparam logic [3:0] NOP = 4'h1, RRMOVQ = 4'h2, MRMOVQ = 4'h5, OPQ = 4'h6;
  localparam logic [3:0] JXX = 4'h7, RET = 4'h9, POPQ = 4'hB, RN = 4'hF;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 4'd4;

  typedef struct packed {
    logic       r;
    logic [3:0] di, sa, sb, ei, edm;
    logic       ec;
    logic [2:0] ms, ws;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic       e_cnd;
  logic [2:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en;
  logic [2:0] stat;
  logic       halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt, mispred_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  string       name_q[$];

  y86_pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc_en(set_cc_en),
    .stat(stat), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  function automatic stim_t mk(input logic r, input logic [3:0] di, sa, sb, ei, edm,
                               input logic ec, input logic [2:0] ms, ws);
    stim_t s;
    s = '{r: r, di: di, sa: sa, sb: sb, ei: ei, edm: edm, ec: ec, ms: ms, ws: ws};
    return s;
  endfunction

  function automatic stim_t idle(input logic r);
    return mk(r, NOP, RN, RN, NOP, RN, 1'b0, AOK, AOK);
  endfunction

  // Observed vector: {F,D,Db,Eb,Mb,W,cc} stat halted
  function automatic logic [10:0] obs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, stat, halted};
  endfunction

  // Drive one cycle of inputs and record what the DUT must show for it.
  task automatic apply(input stim_t s, input logic [10:0] e, input string nm);
    rst = s.r; D_icode = s.di; d_srcA = s.sa; d_srcB = s.sb; E_icode = s.ei;
    E_dstM = s.edm; e_cnd = s.ec; m_stat = s.ms; W_stat = s.ws;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    stim_t st[4]; logic [10:0] ex[4]; logic [10:0] e; string nm;
    st[0] = mk(1, NOP, RN, RN, OPQ, RN, 0, AOK, AOK);    ex[0] = {7'b0011100, 3'd1, 1'b0};
    st[1] = mk(1, RET, 3, RN, MRMOVQ, 3, 0, ADR, ADR);   ex[1] = {7'b0011100, 3'd1, 1'b0};
    st[2] = idle(0);                                     ex[2] = {7'b0000000, 3'd1, 1'b0};
    st[3] = mk(0, NOP, RN, RN, OPQ, RN, 0, AOK, AOK);    ex[3] = {7'b0000001, 3'd1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i], "reset");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[6]; logic [10:0] ex[6]; logic [10:0] e; string nm;
    st[0] = mk(0, OPQ, 3, RN, MRMOVQ, 3, 0, AOK, AOK);  ex[0] = {7'b1101000, 3'd1, 1'b0};
    st[1] = mk(0, OPQ, 3, RN, NOP, RN, 0, AOK, AOK);    ex[1] = {7'b0000000, 3'd1, 1'b0};
    st[2] = mk(0, OPQ, 2, 5, POPQ, 5, 0, AOK, AOK);     ex[2] = {7'b1101000, 3'd1, 1'b0};
    st[3] = mk(0, OPQ, RN, RN, MRMOVQ, RN, 0, AOK, AOK); ex[3] = {7'b0000000, 3'd1, 1'b0};
    st[4] = mk(0, OPQ, 2, 4, MRMOVQ, 3, 0, AOK, AOK);   ex[4] = {7'b0000000, 3'd1, 1'b0};
    st[5] = mk(0, OPQ, 3, RN, RRMOVQ, 3, 0, AOK, AOK);  ex[5] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i], "load_use");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mispred();
    stim_t st[4]; logic [10:0] ex[4]; logic [10:0] e; string nm;
    st[0] = mk(0, NOP, RN, RN, JXX, RN, 0, AOK, AOK);   ex[0] = {7'b0011000, 3'd1, 1'b0};
    st[1] = mk(0, NOP, RN, RN, JXX, RN, 1, AOK, AOK);   ex[1] = {7'b0000000, 3'd1, 1'b0};
    st[2] = mk(0, RET, RN, RN, JXX, RN, 0, AOK, AOK);   ex[2] = {7'b0011000, 3'd1, 1'b0};
    st[3] = idle(0);                                    ex[3] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i], "mispred");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // ret window: detect cycle plus RET_DEPTH=3; a second ret mid-window does not reload.
  task automatic test_ret();
    stim_t st[5]; logic [10:0] ex[5]; logic [10:0] e; string nm;
    st[0] = mk(0, RET, RN, RN, NOP, RN, 0, AOK, AOK);   ex[0] = {7'b1010000, 3'd1, 1'b0};
    st[1] = mk(0, RET, RN, RN, NOP, RN, 0, AOK, AOK);   ex[1] = {7'b1010000, 3'd1, 1'b0};
    st[2] = idle(0);                                    ex[2] = {7'b1010000, 3'd1, 1'b0};
    st[3] = idle(0);                                    ex[3] = {7'b1010000, 3'd1, 1'b0};
    st[4] = idle(0);                                    ex[4] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ex[i], "ret");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ret_load_use();
    stim_t st[6]; logic [10:0] ex[6]; logic [10:0] e; string nm;
    st[0] = mk(0, RET, 3, RN, MRMOVQ, 3, 0, AOK, AOK);  ex[0] = {7'b1101000, 3'd1, 1'b0};
    st[1] = mk(0, RET, 3, RN, NOP, RN, 0, AOK, AOK);    ex[1] = {7'b1010000, 3'd1, 1'b0};
    for (int i = 2; i < 5; i++) begin
      st[i] = idle(0);                                  ex[i] = {7'b1010000, 3'd1, 1'b0};
    end
    st[5] = idle(0);                                    ex[5] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i], "ret_load_use");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset mid-ret, in HALT (entered directly from RUN) and mid-DRAIN.
  task automatic test_reset_mid();
    stim_t st[17]; logic [10:0] ex[17]; logic [10:0] e; string nm;
    st[0]  = mk(0, RET, RN, RN, NOP, RN, 0, AOK, AOK); ex[0]  = {7'b1010000, 3'd1, 1'b0};
    st[1]  = idle(0);                                  ex[1]  = {7'b1010000, 3'd1, 1'b0};
    st[2]  = idle(1);                                  ex[2]  = {7'b0011100, 3'd1, 1'b0};
    st[3]  = idle(0);                                  ex[3]  = {7'b0000000, 3'd1, 1'b0};
    st[4]  = mk(0, NOP, RN, RN, OPQ, RN, 0, INS, HLT); ex[4]  = {7'b0000110, 3'd1, 1'b0};
    st[5]  = idle(0);                                  ex[5]  = {7'b1101110, 3'd2, 1'b1};
    st[6]  = idle(1);                                  ex[6]  = {7'b0011100, 3'd2, 1'b1};
    st[7]  = idle(0);                                  ex[7]  = {7'b0000000, 3'd1, 1'b0};
    st[8]  = mk(0, NOP, RN, RN, NOP, RN, 0, ADR, AOK); ex[8]  = {7'b0000100, 3'd1, 1'b0};
    st[9]  = idle(0);                                  ex[9]  = {7'b1011100, 3'd1, 1'b0};
    st[10] = idle(1);                                  ex[10] = {7'b0011100, 3'd1, 1'b0};
    st[11] = idle(0);                                  ex[11] = {7'b0000000, 3'd1, 1'b0};
    st[12] = mk(0, RET, RN, RN, NOP, RN, 0, AOK, AOK); ex[12] = {7'b1010000, 3'd1, 1'b0};
    for (int i = 13; i < 16; i++) begin
      st[i] = idle(0);                                 ex[i]  = {7'b1010000, 3'd1, 1'b0};
    end
    st[16] = idle(0);                                  ex[16] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      apply(st[i], ex[i], "reset_mid");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  // ADR leaves memory, reaches writeback next cycle, then HALT stays sticky.
  task automatic test_exception();
    stim_t st[14]; logic [10:0] ex[14]; logic [10:0] e; string nm;
    st[0] = mk(0, NOP, RN, RN, OPQ, RN, 0, ADR, AOK);  ex[0] = {7'b0000100, 3'd1, 1'b0};
    st[1] = mk(0, NOP, RN, RN, NOP, RN, 0, AOK, ADR);  ex[1] = {7'b1011110, 3'd1, 1'b0};
    for (int i = 2; i < 14; i++) begin
      if (i % 2 == 0) st[i] = mk(0, RET, 3, RN, OPQ, 3, 0, AOK, AOK);
      else            st[i] = mk(0, NOP, RN, RN, JXX, RN, 0, AOK, AOK);
      ex[i] = {7'b1101110, 3'd3, 1'b1};
    end
    for (int i = 0; i < 14; i++) begin
      apply(st[i], ex[i], "exception");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    stim_t st[6]; logic [10:0] ex[6]; logic [10:0] e; string nm;
    st[0] = idle(1);                                   ex[0] = {7'b0011100, 3'd3, 1'b1};
    st[1] = mk(0, RET, RN, RN, NOP, RN, 0, AOK, AOK);  ex[1] = {7'b1010000, 3'd1, 1'b0};
    for (int i = 2; i < 5; i++) begin
      st[i] = idle(0);                                 ex[i] = {7'b1010000, 3'd1, 1'b0};
    end
    st[5] = idle(0);                                   ex[5] = {7'b0000000, 3'd1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i], "perf");
      @(negedge clk);
      e = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s step %0d: got %b want %b", nm, i, obs(), e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd4 || mispred_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_counters: got %0d/%0d/%0d want 4/4/0", stall_cnt, bubble_cnt, mispred_cnt);
    end
  endtask
`endif

  initial begin
    apply(idle(1), 11'b0, "init");
    void'(exp_q.pop_front());
    void'(name_q.pop_front());
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_mispred();
    test_ret();
    test_ret_load_use();
    test_reset_mid();
    test_exception();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
